antirrebote_botones: RTL and testbench

- Upstream input conditioner for the push-button inputs that drive the logic-gate lessons.
- Takes raw, asynchronous, bouncing button levels and produces, per button:
  - a clean debounced level, which drives `boton1` and `boton2` into the gate logic;
  - one-cycle pressed and released pulses for later sequential lessons.
- Each channel has an independent synchronizer and a 4-state confirm FSM.

---
 rtl/antirrebote_pkg.sv | 18 +
 rtl/antirrebote_botones_if.sv | 12 +
 rtl/antirrebote_canal.sv | 133 +++++++++++++
 rtl/antirrebote_botones.sv | 39 +++
 tb/tb_antirrebote_botones.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/antirrebote_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and counter sizing.
package antirrebote_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t ESTABLE_0  = 2'd0;
    localparam estado_t CONFIRMA_1 = 2'd1;
    localparam estado_t ESTABLE_1  = 2'd2;
    localparam estado_t CONFIRMA_0 = 2'd3;

    // Wide enough to hold the larger of the two terminal counts without wrapping.
    function automatic int cnt_width(input int debounce_cycles, input int repeat_cycles);
        int mayor;
        mayor = (debounce_cycles > repeat_cycles) ? debounce_cycles : repeat_cycles;
        return $clog2(mayor + 1);
    endfunction

endpackage

// File: rtl/antirrebote_botones_if.sv
// Button bundle between the raw inputs and the debounced outputs.
interface antirrebote_botones_if #(
    parameter int N_BOTONES = 2
);
    logic [N_BOTONES-1:0] botones_in;
    logic [N_BOTONES-1:0] botones;
    logic [N_BOTONES-1:0] pulsado;
    logic [N_BOTONES-1:0] soltado;

    modport master (output botones_in, input botones, pulsado, soltado);
    modport slave  (input botones_in, output botones, pulsado, soltado);
endinterface

// File: rtl/antirrebote_canal.sv
// One debounced button: synchronizer, 4-state confirm FSM and shared stability counter.
// Auto-repeat of pulsado while held is enabled with ANTIREBOTE_AUTOREPETICION_EN.
module antirrebote_canal
    import antirrebote_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 6250000
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic boton,
    output logic pulsado,
    output logic soltado
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] CNT_CERO = CW'(0);
    localparam logic [CW-1:0] CNT_UNO  = CW'(1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef ANTIREBOTE_AUTOREPETICION_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    estado_t                state_r;
    estado_t                state_nxt_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   pulsado_nxt_s;
    logic                   soltado_nxt_s;
    logic                   boton_r;
    logic                   pulsado_r;
    logic                   soltado_r;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Input synchronizer chain; the raw level is asynchronous to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], boton_in};
        end
    end

    // Next-state logic; the counter restarts on every state change so it never wraps.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pulsado_nxt_s = 1'b0;
        soltado_nxt_s = 1'b0;
        case (state_r)
            ESTABLE_0: begin
                if (s_s) begin
                    state_nxt_s = CONFIRMA_1;
                    cnt_nxt_s   = CNT_CERO;
                end else begin
                    cnt_nxt_s   = CNT_CERO;
                end
            end
            CONFIRMA_1: begin
                if (!s_s) begin
                    state_nxt_s = ESTABLE_0;
                    cnt_nxt_s   = CNT_CERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s   = ESTABLE_1;
                    cnt_nxt_s     = CNT_CERO;
                    pulsado_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_UNO;
                end
            end
            ESTABLE_1: begin
                if (!s_s) begin
                    state_nxt_s = CONFIRMA_0;
                    cnt_nxt_s   = CNT_CERO;
                end else begin
`ifdef ANTIREBOTE_AUTOREPETICION_EN
                    if (cnt_r == REP_LAST) begin
                        cnt_nxt_s     = CNT_CERO;
                        pulsado_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_UNO;
                    end
`else
                    cnt_nxt_s = CNT_CERO;
`endif
                end
            end
            CONFIRMA_0: begin
                if (s_s) begin
                    state_nxt_s = ESTABLE_1;
                    cnt_nxt_s   = CNT_CERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s   = ESTABLE_0;
                    cnt_nxt_s     = CNT_CERO;
                    soltado_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_UNO;
                end
            end
            default: begin
                state_nxt_s = ESTABLE_0;
                cnt_nxt_s   = CNT_CERO;
            end
        endcase
    end

    // State, counter and registered outputs; botones follows the stable level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ESTABLE_0;
            cnt_r     <= CNT_CERO;
            boton_r   <= 1'b0;
            pulsado_r <= 1'b0;
            soltado_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            boton_r   <= (state_nxt_s == ESTABLE_1) || (state_nxt_s == CONFIRMA_0);
            pulsado_r <= pulsado_nxt_s;
            soltado_r <= soltado_nxt_s;
        end
    end

    assign boton   = boton_r;
    assign pulsado = pulsado_r;
    assign soltado = soltado_r;

endmodule

// File: rtl/antirrebote_botones.sv
// Debouncer for N_BOTONES push buttons, one independent channel each.
// Optional auto-repeat: define ANTIREBOTE_AUTOREPETICION_EN.
module antirrebote_botones
    import antirrebote_pkg::*;
#(
    parameter int N_BOTONES       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 6250000
) (
    input logic                  clk,
    input logic                  reset,
    antirrebote_botones_if.slave bus
);

    logic [N_BOTONES-1:0] botones_s;
    logic [N_BOTONES-1:0] pulsado_s;
    logic [N_BOTONES-1:0] soltado_s;

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
        antirrebote_canal #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_canal (
            .clk     (clk),
            .reset   (reset),
            .boton_in(bus.botones_in[i]),
            .boton   (botones_s[i]),
            .pulsado (pulsado_s[i]),
            .soltado (soltado_s[i])
        );
    end

    assign bus.botones = botones_s;
    assign bus.pulsado = pulsado_s;
    assign bus.soltado = soltado_s;

endmodule

// File: tb/tb_antirrebote_botones.sv
// Directed bench for antirrebote_botones with short debounce/repeat counts.
module tb_antirrebote_botones;

    localparam int N   = 2;
    localparam int SYN = 2;
    localparam int DEB = 4;
    localparam int REP = 8;
`ifdef ANTIREBOTE_AUTOREPETICION_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    antirrebote_botones_if #(.N_BOTONES(N)) bus ();

    antirrebote_botones #(
        .N_BOTONES      (N),
        .SYNC_STAGES    (SYN),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {botones, pulsado, soltado}.
    function automatic logic [5:0] obs();
        return {bus.botones, bus.pulsado, bus.soltado};
    endfunction

    task automatic comprobar(input string tag, input logic [5:0] obtenido, input logic [5:0] esperado);
        n_checks++;
        if (obtenido === esperado) begin
            n_pass++;
        end else begin
            $display("FAIL %s: obtenido b/p/s=%b esperado b/p/s=%b", tag, obtenido, esperado);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    // n edges: the first n-1 expect 'antes', edge n expects 'en', edge n+1 expects 'despues'.
    task automatic secuencia(input string tag, input int n, input logic [5:0] antes,
                             input logic [5:0] en, input logic [5:0] despues);
        for (int e = 1; e < n; e++) begin
            paso();
            comprobar($sformatf("%s@%0d", tag, e), obs(), antes);
        end
        paso();
        comprobar($sformatf("%s@%0d", tag, n), obs(), en);
        paso();
        comprobar($sformatf("%s@%0d", tag, n + 1), obs(), despues);
    endtask

    initial begin
        logic [1:0] rep_p;
        rep_p = AUTO ? 2'b11 : 2'b00;

        reset = 1'b0;
        bus.botones_in = 2'b00;
        repeat (3) paso();
        comprobar("reset", obs(), 6'b00_00_00);
        reset = 1'b1;
        paso();
        comprobar("idle", obs(), 6'b00_00_00);

        // Clean press on channel 0, then release.
        bus.botones_in = 2'b01;
        secuencia("pulsa0", 7, 6'b00_00_00, 6'b01_01_00, 6'b01_00_00);
        bus.botones_in = 2'b00;
        secuencia("suelta0", 7, 6'b01_00_00, 6'b00_00_01, 6'b00_00_00);

        // Bounce: 3 cycles high, 1 low, then held high.
        bus.botones_in = 2'b01;
        for (int e = 1; e <= 3; e++) begin
            paso();
            comprobar($sformatf("rebote_alto@%0d", e), obs(), 6'b00_00_00);
        end
        bus.botones_in = 2'b00;
        paso();
        comprobar("rebote_bajo", obs(), 6'b00_00_00);
        bus.botones_in = 2'b01;
        secuencia("rebote", 7, 6'b00_00_00, 6'b01_01_00, 6'b01_00_00);
        bus.botones_in = 2'b00;
        secuencia("suelta_reb", 7, 6'b01_00_00, 6'b00_00_01, 6'b00_00_00);

        // Both channels together, then release channel 1 alone, then channel 0.
        bus.botones_in = 2'b11;
        secuencia("ambos", 7, 6'b00_00_00, 6'b11_11_00, 6'b11_00_00);
        bus.botones_in = 2'b01;
        secuencia("suelta1", 7, 6'b11_00_00, {2'b01, rep_p & 2'b01, 2'b10}, 6'b01_00_00);
        bus.botones_in = 2'b00;
        secuencia("suelta0b", 7, 6'b01_00_00, 6'b00_00_01, 6'b00_00_00);

        // Channel 1 stable high, channel 0 caught in CONFIRMA_1 with cnt = 2 when reset hits.
        bus.botones_in = 2'b10;
        secuencia("pulsa1", 7, 6'b00_00_00, 6'b10_10_00, 6'b10_00_00);
        bus.botones_in = 2'b11;
        for (int e = 1; e <= 5; e++) begin
            paso();
            comprobar($sformatf("confirma@%0d", e), obs(), 6'b10_00_00);
        end
        #3;
        reset = 1'b0;
        #1;
        comprobar("reset_async", obs(), 6'b00_00_00);
        for (int e = 1; e <= 3; e++) begin
            paso();
            comprobar($sformatf("en_reset@%0d", e), obs(), 6'b00_00_00);
        end
        reset = 1'b1;
        secuencia("tras_reset", 7, 6'b00_00_00, 6'b11_11_00, 6'b11_00_00);

        // Held for a long time: repeats every REP cycles only with auto-repeat.
        for (int k = 2; k <= 32; k++) begin
            paso();
            comprobar($sformatf("mantiene@%0d", k), obs(),
                      {2'b11, ((k % REP) == 0) ? rep_p : 2'b00, 2'b00});
        end
        bus.botones_in = 2'b00;
        secuencia("suelta_ambos", 7, 6'b11_00_00, 6'b00_00_11, 6'b00_00_00);
        for (int e = 1; e <= 10; e++) begin
            paso();
            comprobar($sformatf("sin_repeticion@%0d", e), obs(), 6'b00_00_00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
